// File: rtl/mdu_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the operation request and reads back Busy and HI/LO.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Clear;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, MDUOp, A, B, Clear,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDUOp, A, B, Clear,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mdu_unit.sv
// MIPS-style multiply/divide unit with HI/LO registers.
// The result is computed at issue, held for a fixed latency, then committed.
module mdu_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    mdu_op_e            op;
    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, new_res;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    // Operands are sign- or zero-extended to 2*WIDTH so one multiplier serves both flavours.
    always_comb begin
        op        = mdu_op_e'(bus.MDUOp);
        is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext     = is_signed ? {{WIDTH{bus.A[WIDTH-1]}}, bus.A} : {{WIDTH{1'b0}}, bus.A};
        b_ext     = is_signed ? {{WIDTH{bus.B[WIDTH-1]}}, bus.B} : {{WIDTH{1'b0}}, bus.B};
        product   = a_ext * b_ext;

        a_neg   = is_signed & bus.A[WIDTH-1];
        b_neg   = is_signed & bus.B[WIDTH-1];
        a_mag   = a_neg ? -bus.A : bus.A;
        b_mag   = b_neg ? -bus.B : bus.B;
        divisor = (bus.B == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        // Most-negative / -1 falls out naturally: the magnitude wraps back to A.
        quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;

        new_res = '0;
        case (op)
            OP_MULT, OP_MULTU: new_res = product;
            OP_MADD, OP_MADDU: new_res = {hi_q, lo_q} + product;
            OP_MSUB, OP_MSUBU: new_res = {hi_q, lo_q} - product;
            OP_DIV, OP_DIVU: begin
                if (bus.B == '0) begin
                    new_res = {bus.A, {WIDTH{1'b1}}};
                end else begin
                    new_res = {rem, quot};
                end
            end
            default: new_res = '0;
        endcase
    end

    // Clear outranks both commit and issue; Start is ignored while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;

        if (bus.Clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - ONE_CNT;
            if (cnt_q == ONE_CNT) begin
                hi_d    = res_q[2*WIDTH-1:WIDTH];
                lo_d    = res_q[WIDTH-1:0];
                state_d = ST_IDLE;
            end
        end else if (bus.Start) begin
            case (op)
                OP_MTHI: hi_d = bus.A;
                OP_MTLO: lo_d = bus.A;
                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    res_d   = new_res;
                    cnt_d   = MUL_CNT;
                    state_d = ST_BUSY;
                end
                OP_DIV, OP_DIVU: begin
                    res_d   = new_res;
                    cnt_d   = DIV_CNT;
                    state_d = ST_BUSY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign bus.Busy = (state_q == ST_BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Randomized and directed bench for mdu_unit against an arithmetic HI/LO model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu_unit;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit_if #(.WIDTH(WIDTH)) bus ();

    mdu_unit #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO as one 64-bit accumulator, plain SV integer arithmetic.
    task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        int          sa, sb, q, r;
        longint      sp;
        logic [63:0] ua, ub, up, acc;
        sa  = a;
        sb  = b;
        sp  = longint'(sa) * longint'(sb);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        up  = ua * ub;
        acc = {m_hi, m_lo};
        lat = 0;
        case (op)
            4'd1: begin acc = sp;       lat = MUL_LAT; end
            4'd2: begin acc = up;       lat = MUL_LAT; end
            4'd5: begin acc = acc + sp; lat = MUL_LAT; end
            4'd6: begin acc = acc + up; lat = MUL_LAT; end
            4'd7: begin acc = acc - sp; lat = MUL_LAT; end
            4'd8: begin acc = acc - up; lat = MUL_LAT; end
            4'd3: begin
                lat = DIV_LAT;
                if (b == 32'h0) acc = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) acc = {32'h0, a};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    acc = {r, q};
                end
            end
            4'd4: begin
                lat = DIV_LAT;
                if (b == 32'h0) acc = {a, 32'hFFFF_FFFF};
                else acc = {a % b, a / b};
            end
            4'd9:  acc[63:32] = a;
            4'd10: acc[31:0]  = a;
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
    endtask

    // Issue one op, then follow Busy until it drops, checking hold, latency and result.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi, old_lo;
        int          lat, cycles;
        old_hi = m_hi;
        old_lo = m_lo;
        refModel(op, a, b, lat);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDUOp = 4'($urandom_range(0, 15));
        bus.A     = $urandom;
        bus.B     = $urandom;
        cycles    = 0;
        while (bus.Busy !== 1'b0 && cycles < 200) begin
            cycles++;
            checkOutput("hold_hi", bus.HI, old_hi);
            checkOutput("hold_lo", bus.LO, old_lo);
            @(negedge clk);
        end
        checkOutput("busy_cycles", cycles, lat);
        checkOutput("hi", bus.HI, m_hi);
        checkOutput("lo", bus.LO, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, cycles;
        logic [31:0] hold_hi, hold_lo;
        checks    = 0;
        errors    = 0;
        m_hi      = '0;
        m_lo      = '0;
        reset     = 1'b0;
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Clear = 1'b0;

        #12;
        checkOutput("reset_hi", bus.HI, 32'h0);
        checkOutput("reset_lo", bus.LO, 32'h0);
        checkOutput("reset_busy", bus.Busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'd2);
        checkOutput("mult_hi", bus.HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo", bus.LO, 32'hFFFF_FFFE);
        applyStimulus(4'd2, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu_hi", bus.HI, 32'h0000_0001);
        checkOutput("multu_lo", bus.LO, 32'hFFFF_FFFE);
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_lo", bus.LO, 32'hFFFF_FFFD);
        checkOutput("div_hi", bus.HI, 32'hFFFF_FFFF);
        applyStimulus(4'd4, 32'd7, 32'd0);
        checkOutput("divu0_lo", bus.LO, 32'hFFFF_FFFF);
        checkOutput("divu0_hi", bus.HI, 32'd7);
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf_lo", bus.LO, 32'h8000_0000);
        checkOutput("divovf_hi", bus.HI, 32'h0);
        applyStimulus(4'd9, 32'd0, 32'd0);
        applyStimulus(4'd10, 32'd10, 32'd0);
        applyStimulus(4'd5, 32'd3, 32'd4);
        checkOutput("madd_hi", bus.HI, 32'h0);
        checkOutput("madd_lo", bus.LO, 32'd22);
        applyStimulus(4'd8, 32'd1, 32'd23);
        checkOutput("msubu_hi", bus.HI, 32'hFFFF_FFFF);
        checkOutput("msubu_lo", bus.LO, 32'hFFFF_FFFF);

        // Clear on busy cycle 3 together with a fresh Start.
        hold_hi = m_hi;
        hold_lo = m_lo;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd1; bus.A = 32'd9; bus.B = 32'd9;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        bus.Clear = 1'b1; bus.Start = 1'b1; bus.MDUOp = 4'd2; bus.A = 32'd3; bus.B = 32'd3;
        @(negedge clk);
        bus.Clear = 1'b0; bus.Start = 1'b0;
        checkOutput("clr_busy", bus.Busy, 1'b0);
        checkOutput("clr_hi", bus.HI, hold_hi);
        checkOutput("clr_lo", bus.LO, hold_lo);
        repeat (MUL_LAT + 2) @(negedge clk);
        checkOutput("clr_nostart_busy", bus.Busy, 1'b0);
        checkOutput("clr_nostart_lo", bus.LO, hold_lo);

        // Clear landing on the commit edge must still win.
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd5; bus.A = 32'd100; bus.B = 32'd100;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (MUL_LAT - 1) @(negedge clk);
        bus.Clear = 1'b1;
        @(negedge clk);
        bus.Clear = 1'b0;
        checkOutput("clrcommit_busy", bus.Busy, 1'b0);
        checkOutput("clrcommit_hi", bus.HI, hold_hi);
        checkOutput("clrcommit_lo", bus.LO, hold_lo);

        // mtlo issued while a div is in flight is dropped.
        refModel(4'd3, 32'd100, 32'd7, lat);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd3; bus.A = 32'd100; bus.B = 32'd7;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd10; bus.A = 32'd5;
        @(negedge clk);
        bus.Start = 1'b0;
        cycles = 0;
        while (bus.Busy !== 1'b0 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("busydrop_cycles", cycles, DIV_LAT - 1);
        checkOutput("busydrop_lo", bus.LO, 32'd14);
        checkOutput("busydrop_hi", bus.HI, 32'd2);

        // Asynchronous reset between clock edges, with a Start held during reset.
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd3; bus.A = 32'd1000; bus.B = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset_hi", bus.HI, 32'h0);
        checkOutput("areset_lo", bus.LO, 32'h0);
        checkOutput("areset_busy", bus.Busy, 1'b0);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDUOp = 4'd9; bus.A = 32'h55;
        @(negedge clk);
        bus.Start = 1'b0;
        checkOutput("startinreset_hi", bus.HI, 32'h0);
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        applyStimulus(4'd1, 32'd7, 32'd6);
        checkOutput("postreset_lo", bus.LO, 32'd42);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
